// File: rtl/pic_priority_arbiter.sv
// rtl/pic_priority_arbiter.sv - 8259A-style rotating priority resolver with in-service tracking
module pic_priority_arbiter #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irr,
  input  logic [NUM_IRQ-1:0] imr,
  input  logic               rotate_on_eoi,
  input  logic               aeoi,
  input  logic               eoi,
  input  logic               eoi_spec,
  input  logic [ID_W-1:0]    eoi_id,
  input  logic               set_prio,
  input  logic [ID_W-1:0]    set_prio_id,
  input  logic               int_ack,
  output logic               int_req,
  output logic [ID_W-1:0]    int_id,
  output logic [NUM_IRQ-1:0] isr,
  output logic [ID_W-1:0]    lowest_prio
);

  localparam logic [ID_W:0]   NUM_IRQ_W = (ID_W+1)'(NUM_IRQ);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_IRQ - 1);

  logic               r_int_req;
  logic [ID_W-1:0]    r_int_id;
  logic [NUM_IRQ-1:0] r_isr;
  logic [ID_W-1:0]    r_lowest;

  logic [NUM_IRQ-1:0] w_pend;
  logic               w_cand_found;
  logic [ID_W-1:0]    w_cand_id;
  int                 w_cand_rank;
  logic               w_isr_found;
  logic [ID_W-1:0]    w_isr_top;
  int                 w_isr_rank;
  logic               w_req_valid;
  logic               w_ack;
  logic               w_eoi_id_ok;
  logic               w_prio_id_ok;
  logic [NUM_IRQ-1:0] w_isr_clr;
  logic [NUM_IRQ-1:0] w_isr_set;
  logic [ID_W-1:0]    w_lowest_nxt;

  // Line holding priority rank 'rank' (0 = highest) given the current lowest-priority line.
  function automatic logic [ID_W-1:0] f_line(input int rank, input logic [ID_W-1:0] low);
    int v;
    v = int'(low) + 1 + rank;
    if (v >= NUM_IRQ) v = v - NUM_IRQ;
    return ID_W'(v);
  endfunction

  assign w_pend       = irr & ~imr;
  assign w_ack        = int_ack & r_int_req;
  assign w_eoi_id_ok  = {1'b0, eoi_id} < NUM_IRQ_W;
  assign w_prio_id_ok = {1'b0, set_prio_id} < NUM_IRQ_W;

  // Highest-priority unmasked request; scan lowest rank last so the best one sticks.
  always_comb begin
    w_cand_found = 1'b0;
    w_cand_id    = '0;
    w_cand_rank  = 0;
    for (int r = NUM_IRQ - 1; r >= 0; r--) begin
      if (w_pend[f_line(r, r_lowest)]) begin
        w_cand_found = 1'b1;
        w_cand_id    = f_line(r, r_lowest);
        w_cand_rank  = r;
      end
    end
  end

  // Highest-priority line currently in service.
  always_comb begin
    w_isr_found = 1'b0;
    w_isr_top   = '0;
    w_isr_rank  = 0;
    for (int r = NUM_IRQ - 1; r >= 0; r--) begin
      if (r_isr[f_line(r, r_lowest)]) begin
        w_isr_found = 1'b1;
        w_isr_top   = f_line(r, r_lowest);
        w_isr_rank  = r;
      end
    end
  end

  // Fully nested: only a strictly higher-priority request may interrupt the current service.
  assign w_req_valid = w_cand_found && (!w_isr_found || (w_cand_rank < w_isr_rank));

  // ISR clear/set masks; clears see the pre-ack ISR and the ack set is OR-ed in afterwards.
  always_comb begin
    w_isr_clr = '0;
    w_isr_set = '0;
    if (eoi && w_isr_found)     w_isr_clr[w_isr_top] = 1'b1;
    if (eoi_spec && w_eoi_id_ok) w_isr_clr[eoi_id]   = 1'b1;
    if (w_ack && !aeoi)          w_isr_set[r_int_id] = 1'b1;
  end

  // Rotation sources in ascending precedence: EOI rotate, auto-EOI rotate, specific rotation.
  always_comb begin
    w_lowest_nxt = r_lowest;
    if (eoi && rotate_on_eoi && w_isr_found) w_lowest_nxt = w_isr_top;
    if (w_ack && aeoi && rotate_on_eoi)      w_lowest_nxt = r_int_id;
    if (set_prio && w_prio_id_ok)            w_lowest_nxt = set_prio_id;
  end

  // State update; the ack edge forces int_req low and skips evaluation for that cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_int_req <= 1'b0;
      r_int_id  <= '0;
      r_isr     <= '0;
      r_lowest  <= LAST_ID;
    end else begin
      r_isr    <= (r_isr & ~w_isr_clr) | w_isr_set;
      r_lowest <= w_lowest_nxt;
      if (w_ack) begin
        r_int_req <= 1'b0;
      end else begin
        r_int_req <= w_req_valid;
        if (w_req_valid) r_int_id <= w_cand_id;
      end
    end
  end

  assign int_req     = r_int_req;
  assign int_id      = r_int_id;
  assign isr         = r_isr;
  assign lowest_prio = r_lowest;

endmodule
